// File: rtl/alu_cmd_driver.sv
// Command-queue initiator for the 4-bit signed ALU: issues queued ops,
// samples C after a fixed latency, self-checks and returns responses.
module alu_cmd_driver #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [1:0]       alu_opcode,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [4:0]       alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_c,
    output logic [4:0]       rsp_expected,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       count_q, count_d;
    logic [9:0]        mem_q [DEPTH];
    logic [1:0]        op_q, op_d;
    logic [3:0]        a_q, a_d, b_q, b_d;
    logic              rv_q, rv_d;
    logic [4:0]        rc_q, rc_d, re_q, re_d;
    logic              rm_q, rm_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              push, pop;
    logic [4:0]        expected;
    logic [9:0]        head;

    assign cmd_ready    = (count_q != (AW+1)'(DEPTH));
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state_q == IDLE) && (count_q != '0);
    assign head         = mem_q[rd_q];
    assign busy         = (count_q != '0) || (state_q != IDLE);
    assign alu_opcode   = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_valid    = rv_q;
    assign rsp_c        = rc_q;
    assign rsp_expected = re_q;
    assign rsp_mismatch = rm_q;
    assign err_count    = err_q;

    // Reference model works on the operands currently held on the ALU bus
    always_comb begin
        unique case (op_q)
            2'b00: expected = {a_q[3], a_q} + {b_q[3], b_q};
            2'b01: expected = {a_q[3], a_q} - {b_q[3], b_q};
            2'b10: expected = ~{a_q[3], a_q};
            2'b11: expected = {4'b0000, |b_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rv_d    = rv_q;
        rc_d    = rc_q;
        re_d    = re_q;
        rm_d    = rm_q;
        err_d   = err_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    {op_d, a_d, b_d} = head;
                    cnt_d   = LW'(ALU_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LW'(1);
                end else begin
                    rc_d    = alu_c;
                    re_d    = expected;
                    rm_d    = (alu_c != expected);
                    rv_d    = 1'b1;
                    state_d = RESP;
                    if ((alu_c != expected) && (err_q != '1))
                        err_d = err_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rv_q    <= 1'b0;
            rc_q    <= '0;
            re_q    <= '0;
            rm_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rv_q    <= rv_d;
            rc_q    <= rc_d;
            re_q    <= re_d;
            rm_q    <= rm_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= {cmd_opcode, cmd_a, cmd_b};
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: three instances cover default,
// saturating faulty-ALU and long-latency configurations.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset      [3];
    logic       cmd_valid  [3];
    logic       cmd_ready  [3];
    logic [1:0] cmd_opcode [3];
    logic [3:0] cmd_a      [3];
    logic [3:0] cmd_b      [3];
    logic [1:0] alu_opcode [3];
    logic [3:0] alu_a      [3];
    logic [3:0] alu_b      [3];
    logic [4:0] alu_c      [3];
    logic       rsp_valid  [3];
    logic       rsp_ready  [3];
    logic [4:0] rsp_c      [3];
    logic [4:0] rsp_exp    [3];
    logic       rsp_mm     [3];
    logic       busy       [3];
    logic [7:0] err0, err2;
    logic [1:0] err1;
    logic [4:0] p2a, p2b;

    int nvec  = 0;
    int nfail = 0;

    alu_cmd_driver #(.DEPTH(4), .ALU_LATENCY(1), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset[0]), .cmd_valid(cmd_valid[0]),
        .cmd_ready(cmd_ready[0]), .cmd_opcode(cmd_opcode[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .alu_opcode(alu_opcode[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_c(alu_c[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_c(rsp_c[0]), .rsp_expected(rsp_exp[0]),
        .rsp_mismatch(rsp_mm[0]), .err_count(err0), .busy(busy[0])
    );

    alu_cmd_driver #(.DEPTH(4), .ALU_LATENCY(1), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset[1]), .cmd_valid(cmd_valid[1]),
        .cmd_ready(cmd_ready[1]), .cmd_opcode(cmd_opcode[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .alu_opcode(alu_opcode[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_c(alu_c[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_c(rsp_c[1]), .rsp_expected(rsp_exp[1]),
        .rsp_mismatch(rsp_mm[1]), .err_count(err1), .busy(busy[1])
    );

    alu_cmd_driver #(.DEPTH(4), .ALU_LATENCY(3), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset[2]), .cmd_valid(cmd_valid[2]),
        .cmd_ready(cmd_ready[2]), .cmd_opcode(cmd_opcode[2]),
        .cmd_a(cmd_a[2]), .cmd_b(cmd_b[2]), .alu_opcode(alu_opcode[2]),
        .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_c(alu_c[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_c(rsp_c[2]), .rsp_expected(rsp_exp[2]),
        .rsp_mismatch(rsp_mm[2]), .err_count(err2), .busy(busy[2])
    );

    function automatic logic [4:0] alu_f(input logic [1:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        logic [4:0] r;
        case (op)
            2'b00:   r = {a[3], a} + {b[3], b};
            2'b01:   r = {a[3], a} - {b[3], b};
            2'b10:   r = ~{a[3], a};
            default: r = {4'b0000, |b};
        endcase
        return r;
    endfunction

    // u0: good ALU, latency 1; u1: ALU off by +1; u2: good ALU, latency 3
    always @(posedge clk) begin
        alu_c[0] <= alu_f(alu_opcode[0], alu_a[0], alu_b[0]);
        alu_c[1] <= alu_f(alu_opcode[1], alu_a[1], alu_b[1]) + 5'd1;
        p2a      <= alu_f(alu_opcode[2], alu_a[2], alu_b[2]);
        p2b      <= p2a;
        alu_c[2] <= p2b;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int k, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input string tag);
        bit ok = 0;
        cmd_opcode[k] = op;
        cmd_a[k]      = a;
        cmd_b[k]      = b;
        cmd_valid[k]  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (cmd_ready[k]) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_accept"}, 16'(ok), 16'd1);
        @(posedge clk);
        #1;
        cmd_valid[k] = 1'b0;
    endtask

    task automatic get_rsp(input int k, input logic [4:0] c,
                           input logic [4:0] e, input logic mm,
                           input int lat, input string tag);
        bit seen = 0;
        int n = 0;
        rsp_ready[k] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid[k]) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_valid"}, 16'(seen), 16'd1);
        if (lat >= 0)
            chk({tag, "_latency"}, 16'(n), 16'(lat));
        chk({tag, "_c"}, 16'(rsp_c[k]), 16'(c));
        chk({tag, "_expected"}, 16'(rsp_exp[k]), 16'(e));
        chk({tag, "_mismatch"}, 16'(rsp_mm[k]), 16'(mm));
        @(posedge clk);
        #1;
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        bit   ok;
        bit   stale;
        int   acc;
        int   errexp [5];
        errexp = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 3; k++) begin
            reset[k]      = 1'b1;
            cmd_valid[k]  = 1'b0;
            cmd_opcode[k] = 2'b00;
            cmd_a[k]      = 4'd0;
            cmd_b[k]      = 4'd0;
            rsp_ready[k]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        @(negedge clk);
        chk("por_cmd_ready", 16'(cmd_ready[0]), 16'd1);
        chk("por_rsp_valid", 16'(rsp_valid[0]), 16'd0);
        chk("por_busy", 16'(busy[0]), 16'd0);
        chk("por_err", 16'(err0), 16'd0);
        @(posedge clk);
        #1;

        // Mid-stream reset with one response pending and one queued
        issue(0, 2'b00, 4'd7, 4'd7, "pre1");
        issue(0, 2'b00, 4'd1, 4'd1, "pre2");
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rsp_valid", 16'(rsp_valid[0]), 16'd1);
        reset[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
        chk("rst_rsp_c", 16'(rsp_c[0]), 16'd0);
        chk("rst_rsp_exp", 16'(rsp_exp[0]), 16'd0);
        chk("rst_rsp_mm", 16'(rsp_mm[0]), 16'd0);
        chk("rst_alu_op", 16'(alu_opcode[0]), 16'd0);
        chk("rst_alu_a", 16'(alu_a[0]), 16'd0);
        chk("rst_alu_b", 16'(alu_b[0]), 16'd0);
        chk("rst_busy", 16'(busy[0]), 16'd0);
        chk("rst_cmd_ready", 16'(cmd_ready[0]), 16'd1);
        chk("rst_err", 16'(err0), 16'd0);
        @(posedge clk);
        #1;

        issue(0, 2'b00, 4'd3, 4'd4, "add34");
        get_rsp(0, 5'd7, 5'd7, 1'b0, 4, "add34");

        issue(0, 2'b01, 4'b1000, 4'd1, "sub_m8_1");
        get_rsp(0, 5'b10111, 5'b10111, 1'b0, -1, "sub_m8_1");
        issue(0, 2'b00, 4'b1000, 4'b1000, "add_m8_m8");
        get_rsp(0, 5'b10000, 5'b10000, 1'b0, -1, "add_m8_m8");
        issue(0, 2'b10, 4'd5, 4'd0, "not5");
        get_rsp(0, 5'b11010, 5'b11010, 1'b0, -1, "not5");
        issue(0, 2'b11, 4'hF, 4'd0, "or_b0");
        get_rsp(0, 5'd0, 5'd0, 1'b0, -1, "or_b0");
        issue(0, 2'b11, 4'd0, 4'b1000, "or_bm8");
        get_rsp(0, 5'd1, 5'd1, 1'b0, -1, "or_bm8");

        // Consumer stalled: 4 queued plus 1 in flight
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            cmd_opcode[0] = 2'b00;
            cmd_a[0]      = 4'(i + 1);
            cmd_b[0]      = 4'(i);
            cmd_valid[0]  = 1'b1;
            ok = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (cmd_ready[0]) begin
                    ok = 1;
                    break;
                end
            end
            if (ok) begin
                @(posedge clk);
                #1;
                cmd_valid[0] = 1'b0;
                acc++;
            end else begin
                cmd_valid[0] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        chk("bp_accepted", 16'(acc), 16'd5);
        @(negedge clk);
        chk("bp_cmd_ready_full", 16'(cmd_ready[0]), 16'd0);
        chk("bp_busy", 16'(busy[0]), 16'd1);
        @(posedge clk);
        #1;
        get_rsp(0, 5'd1, 5'd1, 1'b0, -1, "bp_r0");
        @(negedge clk);
        chk("bp_ready_before_pop", 16'(cmd_ready[0]), 16'd0);
        @(negedge clk);
        chk("bp_ready_after_pop", 16'(cmd_ready[0]), 16'd1);
        @(posedge clk);
        #1;
        get_rsp(0, 5'd3, 5'd3, 1'b0, -1, "bp_r1");
        get_rsp(0, 5'd5, 5'd5, 1'b0, -1, "bp_r2");
        get_rsp(0, 5'd7, 5'd7, 1'b0, -1, "bp_r3");
        get_rsp(0, 5'd9, 5'd9, 1'b0, -1, "bp_r4");

        // Faulty ALU returns C+1; 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            issue(1, 2'b00, 4'(i), 4'd1, "flt");
            get_rsp(1, 5'(i + 2), 5'(i + 1), 1'b1, -1, "flt");
            chk($sformatf("flt_err%0d", i), 16'(err1), 16'(errexp[i]));
        end

        // Reset on the second WAIT cycle of a latency-3 op
        issue(2, 2'b00, 4'd2, 4'd3, "lat3_pre");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset[2] = 1'b1;
        @(posedge clk);
        #1;
        reset[2] = 1'b0;
        @(negedge clk);
        chk("w_rst_rsp_valid", 16'(rsp_valid[2]), 16'd0);
        chk("w_rst_err", 16'(err2), 16'd0);
        chk("w_rst_busy", 16'(busy[2]), 16'd0);
        chk("w_rst_cmd_ready", 16'(cmd_ready[2]), 16'd1);
        chk("w_rst_alu_a", 16'(alu_a[2]), 16'd0);
        stale = 0;
        rsp_ready[2] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid[2]) stale = 1;
        end
        rsp_ready[2] = 1'b0;
        chk("w_rst_no_stale", 16'(stale), 16'd0);
        @(posedge clk);
        #1;
        issue(2, 2'b00, 4'd1, 4'd1, "lat3_add11");
        get_rsp(2, 5'd2, 5'd2, 1'b0, 6, "lat3_add11");

        chk("final_err0", 16'(err0), 16'd0);
        chk("final_err2", 16'(err2), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
